k12_nonce_dispatcher: RTL and testbench

- Upstream/downstream wrapper stage around one K12 PoW core.
- Accepts a mining job (blob, target, start nonce, nonce count), issues one load pulse per nonce to the PoW core, and waits a fixed hash latency for each result.
- Samples the core's store/hash outputs and pairs each hit with the nonce that produced it.
- Presents hits on a valid/ready result port and pulses done when the job is exhausted or aborted.

---
 rtl/k12_nonce_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_k12_nonce_dispatcher.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k12_nonce_dispatcher.sv
// k12_nonce_dispatcher: job-to-core nonce sequencer for one K12 PoW core.
// Accepts a mining job and sends one load per nonce. The core's
// hash/store outputs are sampled a fixed latency after each load. Hits
// go to a single-entry valid/ready result slot.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   job_*              job offer (blob, target, first nonce, count)
//   abort              drop the running job
//   pow_*              PoW core load/nonce/blob/target, store/hash back
//   res_*              hit result handshake (nonce + hash)
//   busy, done         job in progress, one-cycle end-of-job pulse
//   hashes_done        nonces sampled in the current/last job
module k12_nonce_dispatcher #(
  parameter int HASH_LATENCY = 13,
  parameter int COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [575:0]       job_blob,
  input  logic [63:0]        job_target,
  input  logic [63:0]        job_nonce,
  input  logic [COUNT_W-1:0] job_count,
  input  logic               abort,
  output logic               pow_load,
  output logic [63:0]        pow_nonce,
  output logic [575:0]       pow_blob,
  output logic [63:0]        pow_target,
  input  logic               pow_store,
  input  logic [255:0]       pow_hash,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [63:0]        res_nonce,
  output logic [255:0]       res_hash,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] hashes_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SAMPLE,
    S_FIN
  } state_t;

  // Counter counts down from the load so that it hits zero in the
  // cycle HASH_LATENCY after pow_load, which is when the core output
  // is captured.
  localparam logic [7:0] CNT_LOAD = 8'(HASH_LATENCY - 1);

  state_t             state;
  logic [7:0]         cnt;
  logic               cap_store;
  logic [255:0]       cap_hash;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] hd_next;
  logic               slot_free;

  assign hd_next = hashes_done + {{(COUNT_W-1){1'b0}}, 1'b1};

  // A load may only go out when the result slot is empty or is being
  // drained this very cycle, so the hit it can produce always has room.
  assign slot_free = !res_valid || res_ready;

  // Combinational so a load can coincide with the draining handshake.
  assign pow_load = (state == S_ISSUE) && slot_free && !abort && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cap_store   <= 1'b0;
      cap_hash    <= '0;
      count_r     <= '0;
      job_ready   <= 1'b1;
      pow_nonce   <= '0;
      pow_blob    <= '0;
      pow_target  <= '0;
      res_valid   <= 1'b0;
      res_nonce   <= '0;
      res_hash    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hashes_done <= '0;
    end else begin
      done <= 1'b0;
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (job_valid && job_ready) begin
            pow_blob    <= job_blob;
            pow_target  <= job_target;
            pow_nonce   <= job_nonce;
            count_r     <= job_count;
            hashes_done <= '0;
            busy        <= 1'b1;
            job_ready   <= 1'b0;
            if (job_count == '0) begin
              state <= S_FIN;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state <= S_FIN;
          end else if (slot_free) begin
            cnt   <= CNT_LOAD;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_FIN;
          end else if (cnt == 8'd0) begin
            cap_store <= pow_store;
            cap_hash  <= pow_hash;
            state     <= S_SAMPLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            state <= S_FIN;
          end else begin
            // A full slot here means a stray hit; keep the older one.
            if (cap_store && !res_valid) begin
              res_valid <= 1'b1;
              res_nonce <= pow_nonce;
              res_hash  <= cap_hash;
            end
            hashes_done <= hd_next;
            pow_nonce   <= pow_nonce + 64'd1;
            if (hd_next == count_r) begin
              state <= S_FIN;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          job_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k12_nonce_dispatcher.sv
// tb_k12_nonce_dispatcher: bench for k12_nonce_dispatcher with a stub
// PoW core and a nonce-list reference model.
module tb_k12_nonce_dispatcher;

  localparam int H  = 13;
  localparam int CW = 32;
  localparam int GAP = H + 2;
  localparam logic [1060:0] RST_VEC = {1'b1, 1060'b0};
  localparam logic [63:0] KM = 64'h9E3779B97F4A7C15;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [575:0]  job_blob;
  logic [63:0]   job_target;
  logic [63:0]   job_nonce;
  logic [CW-1:0] job_count;
  logic          abort;
  logic          pow_load;
  logic [63:0]   pow_nonce;
  logic [575:0]  pow_blob;
  logic [63:0]   pow_target;
  logic          pow_store;
  logic [255:0]  pow_hash;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_nonce;
  logic [255:0]  res_hash;
  logic          busy;
  logic          done;
  logic [CW-1:0] hashes_done;

  k12_nonce_dispatcher #(.HASH_LATENCY(H), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_blob(job_blob), .job_target(job_target),
    .job_nonce(job_nonce), .job_count(job_count),
    .abort(abort),
    .pow_load(pow_load), .pow_nonce(pow_nonce),
    .pow_blob(pow_blob), .pow_target(pow_target),
    .pow_store(pow_store), .pow_hash(pow_hash),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_hash(res_hash),
    .busy(busy), .done(done), .hashes_done(hashes_done)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub core: a hit rule and a hash rule per nonce, valid only in the
  // cycle exactly H after the load; random noise otherwise.
  int          hit_mode;
  logic [63:0] hit_nonce;
  bit          hash_fixed;

  function automatic bit stub_hit(input logic [63:0] n, input int m,
                                  input logic [63:0] hn);
    logic [63:0] p;
    p = n * KM;
    if (m == 1) return n == hn;
    if (m == 2) return p[63:61] < 3'd3;
    return 1'b0;
  endfunction

  function automatic logic [255:0] stub_hash(input logic [63:0] n,
                                             input bit fx);
    if (fx) return {32{8'hAB}};
    return {n * KM, n ^ 64'h5555AAAA0F0FF0F0, ~n, n};
  endfunction

  logic [15:0] pv = '0;
  logic [63:0] pn [16];
  logic [31:0] noise = '0;

  always @(posedge clk) begin
    pv <= {pv[14:0], pow_load};
    pn[0] <= pow_nonce;
    for (int i = 1; i < 16; i++) pn[i] <= pn[i-1];
    noise <= $urandom;
  end

  assign pow_store = pv[H-1] ? stub_hit(pn[H-1], hit_mode, hit_nonce)
                             : noise[0];
  assign pow_hash  = pv[H-1] ? stub_hash(pn[H-1], hash_fixed)
                             : {8{noise}};

  // Monitor
  logic         mon_clr = 1'b0;
  logic [63:0]  load_q [$];
  int           load_cyc [$];
  logic [63:0]  res_nq [$];
  logic [255:0] res_hq [$];
  int done_cnt, done_cyc, acc_cyc, busy_cyc, slot_err, stab_err;
  bit rv_seen;
  logic prev_rv, prev_hs;
  logic [63:0] prev_n;
  logic [255:0] prev_h;

  initial begin
    done_cnt = 0; done_cyc = 0; acc_cyc = 0; busy_cyc = 0;
    slot_err = 0; stab_err = 0; rv_seen = 0;
    prev_rv = 0; prev_hs = 0; prev_n = '0; prev_h = '0;
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      load_q.delete(); load_cyc.delete();
      res_nq.delete(); res_hq.delete();
      done_cnt = 0; busy_cyc = 0; rv_seen = 0;
    end else if (!rst) begin
      if (pow_load) begin
        load_q.push_back(pow_nonce);
        load_cyc.push_back(cyc);
        if (res_valid && !res_ready) slot_err++;
      end
      if (res_valid && res_ready) begin
        res_nq.push_back(res_nonce);
        res_hq.push_back(res_hash);
      end
      if (job_valid && job_ready) acc_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cyc++;
      if (res_valid) rv_seen = 1;
      if (res_valid && prev_rv && !prev_hs &&
          (res_nonce !== prev_n || res_hash !== prev_h)) stab_err++;
    end
    prev_rv = res_valid && !rst;
    prev_hs = res_valid && res_ready;
    prev_n  = res_nonce;
    prev_h  = res_hash;
  end

  function automatic logic [1060:0] out_vec();
    return {job_ready, pow_load, pow_nonce, pow_blob, pow_target,
            res_valid, res_nonce, res_hash, busy, done, hashes_done};
  endfunction

  function automatic logic [575:0] rnd_blob();
    logic [575:0] b;
    for (int i = 0; i < 18; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic launch(input logic [63:0] n, input logic [CW-1:0] c);
    @(posedge clk); #1;
    job_blob = rnd_blob(); job_target = rnd64();
    job_nonce = n; job_count = c; job_valid = 1'b1;
    @(posedge clk); #1 job_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic wait_rv(input int budget);
    for (int i = 0; i < budget && !res_valid; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; job_valid = 0; job_blob = '0; job_target = '0;
    job_nonce = '0; job_count = '0; abort = 0; res_ready = 0;
    hit_mode = 0; hit_nonce = '0; hash_fixed = 0;
    repeat (3) @(posedge clk);
    #1;
    chk++;
    if (out_vec() !== RST_VEC)
      $display("FAIL reset_outputs got %h want %h", out_vec(), RST_VEC);
    else pass++;
    rst = 1'b0;
  endtask

  task automatic test_no_hits();
    logic [575:0] b;
    logic [63:0] t, e;
    clear_mon();
    hit_mode = 0; res_ready = 1;
    launch(64'h10, 3);
    b = job_blob; t = job_target;
    wait_done(200);
    chk++;
    if (load_q.size() != 3)
      $display("FAIL nh_loads got %0d want 3", load_q.size());
    else pass++;
    for (int i = 0; i < 3; i++) begin
      e = 64'h10 + 64'(i);
      chk++;
      if (i >= load_q.size() || load_q[i] !== e)
        $display("FAIL nh_nonce%0d got %h want %h", i,
                 (i < load_q.size()) ? load_q[i] : 'x, e);
      else pass++;
    end
    for (int i = 1; i < 3 && i < load_cyc.size(); i++) begin
      chk++;
      if (load_cyc[i] - load_cyc[i-1] != GAP)
        $display("FAIL nh_gap%0d got %0d want %0d", i,
                 load_cyc[i] - load_cyc[i-1], GAP);
      else pass++;
    end
    chk++;
    if (done_cnt != 1) $display("FAIL nh_done got %0d want 1", done_cnt);
    else pass++;
    chk++;
    if (hashes_done !== 32'd3)
      $display("FAIL nh_hashes got %0d want 3", hashes_done);
    else pass++;
    chk++;
    if (rv_seen) $display("FAIL nh_res_valid got 1 want 0");
    else pass++;
    chk++;
    if (pow_blob !== b || pow_target !== t)
      $display("FAIL nh_blob_target got %h want %h", pow_target, t);
    else pass++;
  endtask

  task automatic test_hit_mid();
    clear_mon();
    hit_mode = 1; hit_nonce = 64'h11; hash_fixed = 1; res_ready = 0;
    launch(64'h10, 3);
    wait_rv(200);
    chk++;
    if (res_valid !== 1'b1 || res_nonce !== 64'h11)
      $display("FAIL hm_nonce got %b/%h want 1/11", res_valid, res_nonce);
    else pass++;
    chk++;
    if (res_hash !== {32{8'hAB}})
      $display("FAIL hm_hash got %h want ab..ab", res_hash);
    else pass++;
    @(posedge clk); #1 res_ready = 1;
    @(posedge clk); #1 res_ready = 0;
    chk++;
    if (res_valid !== 1'b0) $display("FAIL hm_clear got 1 want 0");
    else pass++;
    wait_done(200);
    chk++;
    if (load_q.size() != 3 || res_nq.size() != 1 || hashes_done !== 3)
      $display("FAIL hm_totals got %0d/%0d/%0d want 3/1/3",
               load_q.size(), res_nq.size(), hashes_done);
    else pass++;
    hash_fixed = 0;
  endtask

  task automatic test_stall();
    logic [63:0] n0;
    n0 = rnd64();
    clear_mon();
    hit_mode = 1; hit_nonce = n0; res_ready = 0;
    launch(n0, 2);
    wait_rv(200);
    repeat (40) @(posedge clk);
    #1;
    chk++;
    if (load_q.size() != 1)
      $display("FAIL st_held got %0d loads want 1", load_q.size());
    else pass++;
    res_ready = 1;
    @(negedge clk);
    chk++;
    if ({pow_load, pow_nonce} !== {1'b1, n0 + 64'd1})
      $display("FAIL st_same_cycle got %b/%h want 1/%h",
               pow_load, pow_nonce, n0 + 64'd1);
    else pass++;
    @(posedge clk); #1 res_ready = 0;
    wait_done(200);
    chk++;
    if (res_nq.size() != 1 || res_nq[0] !== n0 ||
        res_hq[0] !== stub_hash(n0, 0))
      $display("FAIL st_result got %0d entries want nonce %h",
               res_nq.size(), n0);
    else pass++;
    chk++;
    if (load_q.size() != 2 || hashes_done !== 2)
      $display("FAIL st_totals got %0d/%0d want 2/2",
               load_q.size(), hashes_done);
    else pass++;
  endtask

  task automatic test_pending_across();
    logic [63:0] n0, n1;
    n0 = rnd64(); n1 = rnd64();
    clear_mon();
    hit_mode = 1; hit_nonce = n0; res_ready = 0;
    launch(n0, 1);
    wait_done(200);
    chk++;
    if (res_valid !== 1'b1 || res_nonce !== n0 || job_ready !== 1'b1)
      $display("FAIL pa_idle got %b/%h want 1/%h", res_valid, res_nonce, n0);
    else pass++;
    hit_mode = 0;
    clear_mon();
    launch(n1, 1);
    repeat (5) @(posedge clk);
    #1;
    chk++;
    if (res_valid !== 1'b1 || res_nonce !== n0 || busy !== 1'b1 ||
        load_q.size() != 0)
      $display("FAIL pa_next_job got %b/%h/%0d want 1/%h/0",
               res_valid, res_nonce, load_q.size(), n0);
    else pass++;
    res_ready = 1;
    @(posedge clk); #1 res_ready = 0;
    wait_done(200);
    chk++;
    if (load_q.size() != 1 || load_q[0] !== n1)
      $display("FAIL pa_load got %0d want nonce %h", load_q.size(), n1);
    else pass++;
  endtask

  task automatic test_wrap();
    clear_mon();
    hit_mode = 0; res_ready = 1;
    launch(64'hFFFF_FFFF_FFFF_FFFF, 2);
    wait_done(200);
    chk++;
    if (load_q.size() != 2 || load_q[0] !== 64'hFFFF_FFFF_FFFF_FFFF ||
        load_q[1] !== 64'h0)
      $display("FAIL wrap_loads got %0d loads want ffff..ffff then 0",
               load_q.size());
    else pass++;
    chk++;
    if (hashes_done !== 2)
      $display("FAIL wrap_hashes got %0d want 2", hashes_done);
    else pass++;
  endtask

  task automatic test_zero_count();
    clear_mon();
    launch(rnd64(), 0);
    repeat (6) @(posedge clk);
    #1;
    chk++;
    if (load_q.size() != 0 || done_cnt != 1)
      $display("FAIL zc_loads_done got %0d/%0d want 0/1",
               load_q.size(), done_cnt);
    else pass++;
    chk++;
    if (busy_cyc != 1 || done_cyc - acc_cyc != 2)
      $display("FAIL zc_timing got busy %0d done+%0d want 1/2",
               busy_cyc, done_cyc - acc_cyc);
    else pass++;
    chk++;
    if (hashes_done !== 0)
      $display("FAIL zc_hashes got %0d want 0", hashes_done);
    else pass++;
  endtask

  task automatic test_abort();
    logic [63:0] n0;
    n0 = rnd64();
    clear_mon();
    hit_mode = 1; hit_nonce = n0 + 64'd1; res_ready = 1;
    launch(n0, 10);
    for (int i = 0; i < 200 && load_q.size() < 2; i++) @(negedge clk);
    repeat (5) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    wait_done(100);
    repeat (30) @(posedge clk);
    #1;
    chk++;
    if (load_q.size() != 2 || rv_seen)
      $display("FAIL ab_loads got %0d loads rv %b want 2/0",
               load_q.size(), rv_seen);
    else pass++;
    chk++;
    if (hashes_done !== 1 || done_cnt != 1 || busy !== 0)
      $display("FAIL ab_end got %0d/%0d want hashes 1 done 1",
               hashes_done, done_cnt);
    else pass++;
    // abort in IDLE is ignored; a job offered with it is accepted
    clear_mon();
    hit_mode = 0;
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1;
    job_nonce = n0; job_count = 1; job_valid = 1;
    @(posedge clk); #1 job_valid = 0; abort = 0;
    wait_done(100);
    chk++;
    if (load_q.size() != 1 || hashes_done !== 1 || done_cnt != 1)
      $display("FAIL ab_idle got %0d/%0d want 1 load 1 hash",
               load_q.size(), hashes_done);
    else pass++;
  endtask

  task automatic test_rst_mid();
    clear_mon();
    hit_mode = 0; res_ready = 1;
    launch(rnd64(), 5);
    for (int i = 0; i < 200 && load_q.size() < 1; i++) @(negedge clk);
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    chk++;
    if (out_vec() !== RST_VEC)
      $display("FAIL rm_outputs got %h want %h", out_vec(), RST_VEC);
    else pass++;
    rst = 0;
    repeat (40) @(posedge clk);
    #1;
    chk++;
    if (done_cnt != 0 || load_q.size() != 1 || busy !== 0)
      $display("FAIL rm_quiet got done %0d loads %0d want 0/1",
               done_cnt, load_q.size());
    else pass++;
  endtask

  task automatic test_random();
    logic [63:0] n0, n;
    logic [CW-1:0] c;
    logic [63:0] en [$];
    logic [255:0] eh [$];
    int bad, gmin;
    hit_mode = 2;
    for (int j = 0; j < 5; j++) begin
      n0 = (j == 4) ? 64'hFFFF_FFFF_FFFF_FFFD : rnd64();
      c = CW'($urandom_range(1, 7));
      clear_mon();
      res_ready = 0;
      launch(n0, c);
      for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
        @(posedge clk); #1 res_ready = ($urandom_range(0, 2) == 0);
      end
      res_ready = 1;
      for (int i = 0; i < 4 && res_valid; i++) @(posedge clk);
      #1 res_ready = 0;
      @(posedge clk); #1;
      en.delete(); eh.delete();
      for (int i = 0; i < int'(c); i++) begin
        n = n0 + 64'(i);
        if (stub_hit(n, 2, '0)) begin
          en.push_back(n); eh.push_back(stub_hash(n, 0));
        end
      end
      bad = 0;
      for (int i = 0; i < int'(c); i++)
        if (i >= load_q.size() || load_q[i] !== n0 + 64'(i)) bad++;
      chk++;
      if (bad != 0 || load_q.size() != int'(c))
        $display("FAIL rnd%0d_loads got %0d loads want %0d",
                 j, load_q.size(), c);
      else pass++;
      bad = 0;
      for (int i = 0; i < en.size(); i++)
        if (i >= res_nq.size() || res_nq[i] !== en[i] ||
            res_hq[i] !== eh[i]) bad++;
      chk++;
      if (bad != 0 || res_nq.size() != en.size())
        $display("FAIL rnd%0d_results got %0d want %0d",
                 j, res_nq.size(), en.size());
      else pass++;
      chk++;
      if (hashes_done !== c || done_cnt != 1)
        $display("FAIL rnd%0d_end got %0d/%0d want %0d/1",
                 j, hashes_done, done_cnt, c);
      else pass++;
      gmin = 1000000;
      for (int i = 1; i < load_cyc.size(); i++)
        if (load_cyc[i] - load_cyc[i-1] < gmin)
          gmin = load_cyc[i] - load_cyc[i-1];
      chk++;
      if (gmin < GAP)
        $display("FAIL rnd%0d_gap got %0d want >= %0d", j, gmin, GAP);
      else pass++;
    end
    hit_mode = 0;
  endtask

  initial begin
    test_reset();
    test_no_hits();
    test_hit_mid();
    test_stall();
    test_pending_across();
    test_wrap();
    test_zero_count();
    test_abort();
    test_rst_mid();
    test_random();
    chk++;
    if (slot_err != 0 || stab_err != 0)
      $display("FAIL slot_rules got %0d/%0d want 0/0", slot_err, stab_err);
    else pass++;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
